// File: rtl/jedro_1_defines.sv
// Shared types and constants for the multi-cycle ALU.
// Optional build macro: JEDRO_1_ALU_BARREL_SHIFT_EN (single-cycle barrel shifter).
package jedro_1_defines;

    // ALU operation encoding: {funct7[5], funct3}
    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'b0000,
        ALU_OP_SLL  = 4'b0001,
        ALU_OP_SLT  = 4'b0010,
        ALU_OP_SLTU = 4'b0011,
        ALU_OP_XOR  = 4'b0100,
        ALU_OP_SRL  = 4'b0101,
        ALU_OP_OR   = 4'b0110,
        ALU_OP_AND  = 4'b0111,
        ALU_OP_SUB  = 4'b1000,
        ALU_OP_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_mc_state_e;

    localparam int unsigned ALU_XLEN    = 32;
    localparam int unsigned ALU_SHAMT_W = $clog2(ALU_XLEN);

    // True for the three shift operations
    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
    endfunction

endpackage

// File: rtl/jedro_1_alu_shifter.sv
// Iterative shifter: moves the working value up to SHIFT_STEP bits per cycle.
module jedro_1_alu_shifter
    import jedro_1_defines::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     left,
    input  logic                     arith,
    input  logic [XLEN-1:0]          operand,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    output logic                     step_done,
    output logic [XLEN-1:0]          result
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned CNT_W   = SHAMT_W + 1;

    logic [XLEN-1:0]  work;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] step;
    logic             left_q;
    logic             arith_q;
    logic [XLEN-1:0]  shifted;

    // Amount moved this cycle and the resulting working value
    always_comb begin
        step = (remaining > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : remaining;
        if (left_q) begin
            shifted = work << step;
        end else if (arith_q) begin
            shifted = XLEN'($signed(work) >>> step);
        end else begin
            shifted = work >> step;
        end
    end

    assign step_done = (remaining != '0) && (remaining <= CNT_W'(SHIFT_STEP));
    assign result    = shifted;

    // Working value and remaining count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            remaining <= '0;
            left_q    <= 1'b0;
            arith_q   <= 1'b0;
        end else if (start) begin
            work      <= operand;
            remaining <= CNT_W'(shamt);
            left_q    <= left;
            arith_q   <= arith;
        end else if (remaining != '0) begin
            work      <= shifted;
            remaining <= remaining - step;
        end
    end

endmodule

// File: rtl/jedro_1_alu_mc.sv
// Handshaked multi-cycle RV32I ALU with iterative shifter.
// Optional build macro: JEDRO_1_ALU_BARREL_SHIFT_EN (all ops single-cycle).
module jedro_1_alu_mc
    import jedro_1_defines::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  alu_op_e         sel_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] res_o,
    output logic            out_valid_o,
    input  logic            out_ready_i
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    alu_mc_state_e      state;
    alu_mc_state_e      state_next;
    logic               accept;
    logic               needs_iter;
    logic               shift_start;
    logic               step_done;
    logic               res_load;
    logic               valid_next;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    op_res;
    logic [XLEN-1:0]    res_next;
    logic [XLEN-1:0]    shift_res;

    assign shamt      = op_b_i[SHAMT_W-1:0];
    assign in_ready_o = (state == IDLE) || ((state == DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

`ifdef JEDRO_1_ALU_BARREL_SHIFT_EN
    assign needs_iter = 1'b0;
    assign step_done  = 1'b0;
    assign shift_res  = '0;
`else
    assign needs_iter = is_shift_op(sel_i) && (shamt != '0);

    jedro_1_alu_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .start     (shift_start),
        .left      (sel_i == ALU_OP_SLL),
        .arith     (sel_i == ALU_OP_SRA),
        .operand   (op_a_i),
        .shamt     (shamt),
        .step_done (step_done),
        .result    (shift_res)
    );
`endif

    // Single-cycle result; a shift reaching here has shamt 0 unless barrel mode
    always_comb begin
        op_res = '0;
        case (sel_i)
            ALU_OP_ADD:  op_res = op_a_i + op_b_i;
            ALU_OP_SUB:  op_res = op_a_i - op_b_i;
            ALU_OP_XOR:  op_res = op_a_i ^ op_b_i;
            ALU_OP_OR:   op_res = op_a_i | op_b_i;
            ALU_OP_AND:  op_res = op_a_i & op_b_i;
            ALU_OP_SLT:  op_res = XLEN'($signed(op_a_i) < $signed(op_b_i));
            ALU_OP_SLTU: op_res = XLEN'(op_a_i < op_b_i);
`ifdef JEDRO_1_ALU_BARREL_SHIFT_EN
            ALU_OP_SLL:  op_res = op_a_i << shamt;
            ALU_OP_SRL:  op_res = op_a_i >> shamt;
            ALU_OP_SRA:  op_res = XLEN'($signed(op_a_i) >>> shamt);
`else
            ALU_OP_SLL,
            ALU_OP_SRL,
            ALU_OP_SRA:  op_res = op_a_i;
`endif
            default:     op_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = needs_iter ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (step_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = needs_iter ? SHIFT : DONE;
                end else if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output control: shifter start, result load and next valid
    always_comb begin
        shift_start = 1'b0;
        res_load    = 1'b0;
        res_next    = res_o;
        valid_next  = (state_next == DONE);
        if (accept && needs_iter) begin
            shift_start = 1'b1;
        end else if (accept) begin
            res_load = 1'b1;
            res_next = op_res;
        end else if ((state == SHIFT) && step_done) begin
            res_load = 1'b1;
            res_next = shift_res;
        end
    end

    // Registered result and valid
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            res_o       <= '0;
            out_valid_o <= 1'b0;
        end else begin
            out_valid_o <= valid_next;
            if (res_load) begin
                res_o <= res_next;
            end
        end
    end

endmodule

// File: tb/tb_jedro_1_alu_mc.sv
// Directed self-checking bench for jedro_1_alu_mc (SHIFT_STEP 1 and 4 instances).
module tb_jedro_1_alu_mc;
    import jedro_1_defines::*;

    logic        clk;
    logic        rstn;

    logic        in_valid, in_ready, out_valid, out_ready;
    alu_op_e     sel;
    logic [31:0] op_a, op_b, res;

    logic        in_valid_4, in_ready_4, out_valid_4, out_ready_4;
    alu_op_e     sel_4;
    logic [31:0] op_a_4, op_b_4, res_4;

    int n_cmp;
    int n_err;

    jedro_1_alu_mc #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sel_i       (sel),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .res_o       (res),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    jedro_1_alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .in_valid_i  (in_valid_4),
        .in_ready_o  (in_ready_4),
        .sel_i       (sel_4),
        .op_a_i      (op_a_4),
        .op_b_i      (op_b_4),
        .res_o       (res_4),
        .out_valid_o (out_valid_4),
        .out_ready_i (out_ready_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request to the step-1 DUT, then scramble the inputs
    task automatic issue(input alu_op_e s, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        sel      = s;
        op_a     = a;
        op_b     = b;
        tick();
        in_valid = 1'b0;
        sel      = ALU_OP_AND;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h1234_5677;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic issue4(input alu_op_e s, input logic [31:0] a, input logic [31:0] b);
        in_valid_4 = 1'b1;
        sel_4      = s;
        op_a_4     = a;
        op_b_4     = b;
        tick();
        in_valid_4 = 1'b0;
        op_a_4     = 32'hFFFF_FFFF;
        op_b_4     = 32'h0000_0007;
    endtask

    task automatic wait_valid4(output int n);
        n = 0;
        while (out_valid_4 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; sel = ALU_OP_ADD; op_a = '0; op_b = '0;
        in_valid_4 = 1'b0; out_ready_4 = 1'b1; sel_4 = ALU_OP_ADD; op_a_4 = '0; op_b_4 = '0;

        #1 rstn = 1'b0;
        #1;
        check("reset_res", res, 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_ready", 32'(in_ready), 32'h1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // ADD wrap, latency 1
        issue(ALU_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        check("add_wrap_valid", 32'(out_valid), 32'h1);
        check("add_wrap_res", res, 32'h0000_0000);

        issue(ALU_OP_SLT, 32'h8000_0000, 32'h0000_0001);
        check("slt_neg", res, 32'h1);
        issue(ALU_OP_SLTU, 32'h8000_0000, 32'h0000_0001);
        check("sltu_big", res, 32'h0);
        issue(ALU_OP_SLT, 32'd5, 32'd5);
        check("slt_equal", res, 32'h0);
        issue(ALU_OP_SUB, 32'h0, 32'h1);
        check("sub_wrap", res, 32'hFFFF_FFFF);
        issue(ALU_OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
        check("or", res, 32'hF0F0_0F0F);
        issue(ALU_OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check("and", res, 32'h0F00_0F00);
        issue(alu_op_e'(4'hF), 32'h1234_5678, 32'h1111_1111);
        check("undef_valid", 32'(out_valid), 32'h1);
        check("undef_res", res, 32'h0);
        tick();

        // SRL by 4 with step 1: four shift cycles after accept
        issue(ALU_OP_SRL, 32'hF000_0000, 32'h0000_0004);
        wait_valid(n);
        check("srl_latency", 32'(n), 32'd4);
        check("srl_res", res, 32'h0F00_0000);
        tick();

        // SRA shamt 31 (b = 0x3F), step 1
        issue(ALU_OP_SRA, 32'h8000_0000, 32'h0000_003F);
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            tick();
        end
        check("sra_busy_cycles", 32'(bad), 32'd0);
        check("sra_valid", 32'(out_valid), 32'h1);
        check("sra_res", res, 32'hFFFF_FFFF);
        tick();

        // Step-4 instance: SLL 1 by 10, then shamt 0 (b = 0x20)
        issue4(ALU_OP_SLL, 32'h1, 32'd10);
        wait_valid4(n);
        check("step4_sll_latency", 32'(n), 32'd3);
        check("step4_sll_res", res_4, 32'h0000_0400);
        tick();
        issue4(ALU_OP_SLL, 32'h1234_5678, 32'h0000_0020);
        wait_valid4(n);
        check("step4_shamt0_latency", 32'(n), 32'd0);
        check("step4_shamt0_res", res_4, 32'h1234_5678);
        tick();

        // Backpressure on an XOR result, then back-to-back ADD on release
        out_ready = 1'b0;
        issue(ALU_OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("xor_res", res, 32'h0FF0_0FF0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res !== 32'h0FF0_0FF0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = ALU_OP_ADD;
        op_a      = 32'd3;
        op_b      = 32'd4;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("b2b_add_valid", 32'(out_valid), 32'h1);
        check("b2b_add_res", res, 32'd7);
        tick();

        // Reset in the middle of a long shift
        issue(ALU_OP_SRL, 32'h8000_0000, 32'd20);
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_res", res, 32'h0);
        @(posedge clk);
        #3 rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check("midrst_no_stale", 32'(bad), 32'd0);
        issue(ALU_OP_ADD, 32'd10, 32'd20);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_res", res, 32'd30);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
